uart_rx_drain_ctrl: RTL and testbench

Controller that sequences reads from the UART receiver's 8x16 RX FIFO and drives the two-digit hex display, with manual-step and auto-advance modes. It also owns receiver recovery: it pulses the receiver/FIFO reset at start-up and after any framing error. It sits between the `uart_rx` datapath (FIFO `rd_en`/`dout`/`empty`/`full`, `error`, `reset`) and the board-level display and button logic.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_dwell_timer.sv | 34 +++
 rtl/uart_rx_drain_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_rx_drain_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: drain FSM state encoding and
// board-level constants.
package uart_pkg;

    localparam int LP_SYS_CLK_hz = 500_000_000;
    localparam int LP_WIDTH      = 8;

    typedef enum logic [1:0] {
        S_RECOVER = 2'd0,
        S_IDLE    = 2'd1,
        S_POP     = 2'd2,
        S_LATCH   = 2'd3
    } drain_state_e;

endpackage

// File: rtl/uart_dwell_timer.sv
// Saturating dwell counter: counts up from 0 after restart and holds at
// P_DWELL_CYCLES-1, where done is raised.
module uart_dwell_timer #(
    parameter int P_DWELL_CYCLES = 50_000_000
) (
    input  logic CLK,
    input  logic reset,
    input  logic restart,
    output logic done
);

    localparam int              LP_CW   = $clog2(P_DWELL_CYCLES);
    localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(P_DWELL_CYCLES - 1);

    logic [LP_CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart)
            cnt_d = '0;
        else if (cnt_q != LP_LAST)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q == LP_LAST);

endmodule

// File: rtl/uart_rx_drain_ctrl.sv
// Drains the UART RX FIFO onto a two-digit hex display (manual step or
// auto-advance) and sequences receiver reset at start-up and after errors.
module uart_rx_drain_ctrl
    import uart_pkg::*;
#(
    parameter int P_WIDTH         = LP_WIDTH,
    parameter int P_DWELL_CYCLES  = 50_000_000,
    parameter int P_RX_RST_CYCLES = 4,
    parameter int P_ERR_CNT_BITS  = 8
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      fifo_empty,
    input  logic                      fifo_full,
    input  logic [P_WIDTH-1:0]        fifo_dout,
    input  logic                      rx_error,
    input  logic                      step,
    input  logic                      auto_mode,
    output logic                      rd_en,
    output logic                      rx_reset,
    output logic [P_WIDTH/2-1:0]      disp_msd,
    output logic [P_WIDTH/2-1:0]      disp_lsd,
    output logic                      disp_valid,
    output logic                      overflow,
    output logic [P_ERR_CNT_BITS-1:0] err_count
);

    localparam int               LP_HW   = P_WIDTH / 2;
    localparam int               LP_RCW  = $clog2(P_RX_RST_CYCLES + 1);
    localparam logic [LP_RCW-1:0] LP_RLAST = LP_RCW'(P_RX_RST_CYCLES);

    drain_state_e              state_q, state_d;
    logic [LP_RCW-1:0]         rcnt_q, rcnt_d;
    logic                      step_pend_q, step_pend_d;
    logic [P_ERR_CNT_BITS-1:0] err_q, err_d;
    logic                      ovf_q, ovf_d;
    logic [LP_HW-1:0]          msd_q, msd_d, lsd_q, lsd_d;
    logic                      dv_q, dv_d;
    logic                      rd_en_q, rx_reset_q;
    logic                      latch, advance, dwell_done;

    uart_dwell_timer #(.P_DWELL_CYCLES(P_DWELL_CYCLES)) u_dwell (
        .CLK     (CLK),
        .reset   (reset),
        .restart (latch),
        .done    (dwell_done)
    );

    assign advance = auto_mode ? (!dv_q || dwell_done) : step_pend_q;

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        step_pend_d = step_pend_q | step;
        err_d       = err_q;
        ovf_d       = ovf_q | fifo_full;
        msd_d       = msd_q;
        lsd_d       = lsd_q;
        dv_d        = dv_q;
        latch       = 1'b0;

        case (state_q)
            S_RECOVER: begin
                if (rcnt_q == LP_RLAST)
                    state_d = S_IDLE;
                else
                    rcnt_d = rcnt_q + 1'b1;
            end
            S_IDLE:  if (advance && !fifo_empty) state_d = S_POP;
            S_POP:   state_d = S_LATCH;
            S_LATCH: begin
                latch   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_RECOVER;
        endcase

        // An error abandons any read in flight; the counter starts at 1 so the
        // recovery pulse is the same length as the one after reset.
        if (state_q != S_RECOVER && rx_error) begin
            state_d = S_RECOVER;
            rcnt_d  = LP_RCW'(1);
            latch   = 1'b0;
            if (err_q != '1)
                err_d = err_q + 1'b1;
        end

        if (latch) begin
            {msd_d, lsd_d} = fifo_dout;
            dv_d           = 1'b1;
            step_pend_d    = step;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_RECOVER;
            rcnt_q      <= '0;
            step_pend_q <= 1'b0;
            err_q       <= '0;
            ovf_q       <= 1'b0;
            msd_q       <= '0;
            lsd_q       <= '0;
            dv_q        <= 1'b0;
            rd_en_q     <= 1'b0;
            rx_reset_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            step_pend_q <= step_pend_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            msd_q       <= msd_d;
            lsd_q       <= lsd_d;
            dv_q        <= dv_d;
            rd_en_q     <= (state_d == S_POP);
            rx_reset_q  <= (state_d == S_RECOVER);
        end
    end

    assign rd_en      = rd_en_q;
    assign rx_reset   = rx_reset_q;
    assign disp_msd   = msd_q;
    assign disp_lsd   = lsd_q;
    assign disp_valid = dv_q;
    assign overflow   = ovf_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Directed bench for uart_rx_drain_ctrl: cycle table for start-up and a manual
// read, then hand sequences for auto pacing, early step, errors and overflow.
module tb_uart_rx_drain_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] fifo_dout = 8'h00;
    logic       rx_error = 1'b0;
    logic       step = 1'b0;
    logic       auto_mode = 1'b0;
    logic       rd_en, rx_reset, disp_valid, overflow;
    logic [3:0] disp_msd, disp_lsd;
    logic [7:0] err_count;

    uart_rx_drain_ctrl #(
        .P_WIDTH(8), .P_DWELL_CYCLES(8), .P_RX_RST_CYCLES(4), .P_ERR_CNT_BITS(8)
    ) dut (
        .CLK(CLK), .reset(reset), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_dout(fifo_dout), .rx_error(rx_error), .step(step), .auto_mode(auto_mode),
        .rd_en(rd_en), .rx_reset(rx_reset), .disp_msd(disp_msd), .disp_lsd(disp_lsd),
        .disp_valid(disp_valid), .overflow(overflow), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst, stp, aut, push;
        logic [7:0] pdat;
        logic       e_rd, e_rxr, e_dv;
        logic [7:0] e_byte;
    } vec_t;

    vec_t       tv[13];
    logic [7:0] fq[$];
    int         nchk = 0, nerr = 0, cyc = 0, rd_pulses = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO model: a read strobe pops the head onto dout for the following cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (rd_en === 1'b1) begin
            rd_pulses++;
            chk("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
            if (fq.size() > 0) fifo_dout = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_disp(input logic [7:0] b, input int bound, output int t);
        int n;
        n = 0;
        while (!(disp_valid === 1'b1 && {disp_msd, disp_lsd} === b) && n < bound) begin
            tick();
            n++;
        end
        t = cyc;
        chk($sformatf("wait_disp_%02h", b), {24'd0, disp_msd, disp_lsd}, {24'd0, b});
    endtask

    function automatic vec_t mk(input logic rst, stp, push, input logic [7:0] pdat,
                                input logic e_rd, e_rxr, e_dv, input logic [7:0] e_byte);
        vec_t v;
        v.rst = rst; v.stp = stp; v.aut = 1'b0; v.push = push; v.pdat = pdat;
        v.e_rd = e_rd; v.e_rxr = e_rxr; v.e_dv = e_dv; v.e_byte = e_byte;
        return v;
    endfunction

    initial begin
        int t0, t1, t2, pn;

        //          rst stp psh data   rd rxr dv byte
        tv[0]  = mk(1, 0, 0, 8'h00,   0, 0, 0, 8'h00);
        tv[1]  = mk(0, 0, 0, 8'h00,   0, 1, 0, 8'h00);
        tv[2]  = mk(0, 0, 1, 8'hA5,   0, 1, 0, 8'h00);
        tv[3]  = mk(0, 0, 0, 8'h00,   0, 1, 0, 8'h00);
        tv[4]  = mk(0, 0, 0, 8'h00,   0, 1, 0, 8'h00);
        tv[5]  = mk(0, 0, 0, 8'h00,   0, 0, 0, 8'h00);
        tv[6]  = mk(0, 0, 0, 8'h00,   0, 0, 0, 8'h00);
        tv[7]  = mk(0, 1, 0, 8'h00,   0, 0, 0, 8'h00);
        tv[8]  = mk(0, 0, 0, 8'h00,   1, 0, 0, 8'h00);
        tv[9]  = mk(0, 0, 0, 8'h00,   0, 0, 0, 8'h00);
        tv[10] = mk(0, 0, 0, 8'h00,   0, 0, 1, 8'hA5);
        tv[11] = mk(0, 0, 0, 8'h00,   0, 0, 1, 8'hA5);
        tv[12] = mk(0, 0, 0, 8'h00,   0, 0, 1, 8'hA5);

        tick();
        tick();
        for (int i = 0; i < 13; i++) begin
            reset = tv[i].rst;
            step = tv[i].stp;
            auto_mode = tv[i].aut;
            if (tv[i].push) push(tv[i].pdat);
            tick();
            chk($sformatf("v%0d_rd_en", i), {31'd0, rd_en}, {31'd0, tv[i].e_rd});
            chk($sformatf("v%0d_rx_reset", i), {31'd0, rx_reset}, {31'd0, tv[i].e_rxr});
            chk($sformatf("v%0d_disp_valid", i), {31'd0, disp_valid}, {31'd0, tv[i].e_dv});
            chk($sformatf("v%0d_disp", i), {24'd0, disp_msd, disp_lsd}, {24'd0, tv[i].e_byte});
            chk($sformatf("v%0d_err_count", i), {24'd0, err_count}, 32'd0);
        end
        step = 1'b0;
        chk("manual_single_rd", rd_pulses, 1);

        // Auto pacing: bytes appear D+2 = 10 cycles apart.
        push(8'h12); push(8'h34); push(8'h56);
        auto_mode = 1'b1;
        wait_disp(8'h12, 30, t0);
        wait_disp(8'h34, 30, t1);
        wait_disp(8'h56, 30, t2);
        chk("auto_gap_1", t1 - t0, 10);
        chk("auto_gap_2", t2 - t1, 10);
        auto_mode = 1'b0;

        // Early step with an empty FIFO is remembered until a byte arrives.
        pn = rd_pulses;
        step = 1'b1; tick(); step = 1'b0;
        repeat (3) tick();
        chk("early_step_no_rd", rd_pulses, pn);
        push(8'h7E);
        tick(); tick();
        chk("early_step_not_yet", {24'd0, disp_msd, disp_lsd}, 32'h56);
        tick();
        chk("early_step_disp", {24'd0, disp_msd, disp_lsd}, 32'h7E);

        // Error during S_POP abandons the read and recovers.
        push(8'h99);
        step = 1'b1; tick(); step = 1'b0;
        tick();
        chk("err_pop_rd_en", {31'd0, rd_en}, 32'd1);
        rx_error = 1'b1; tick(); rx_error = 1'b0;
        chk("err_rx_reset_c1", {31'd0, rx_reset}, 32'd1);
        chk("err_count_1", {24'd0, err_count}, 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("err_rx_reset_c%0d", i), {31'd0, rx_reset}, 32'd1);
        end
        tick();
        chk("err_rx_reset_end", {31'd0, rx_reset}, 32'd0);
        chk("err_disp_kept", {24'd0, disp_msd, disp_lsd}, 32'h7E);
        chk("err_dv_kept", {31'd0, disp_valid}, 32'd1);

        for (int i = 0; i < 299; i++) begin
            rx_error = 1'b1; tick(); rx_error = 1'b0;
            repeat (5) tick();
            if (i == 9) chk("err_count_11", {24'd0, err_count}, 32'd11);
        end
        chk("err_count_sat", {24'd0, err_count}, 32'd255);

        // Overflow is sticky through recovery.
        chk("ovf_initial", {31'd0, overflow}, 32'd0);
        fifo_full = 1'b1; tick(); fifo_full = 1'b0;
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        rx_error = 1'b1; tick(); rx_error = 1'b0;
        repeat (5) tick();
        chk("ovf_after_err", {31'd0, overflow}, 32'd1);

        // Reset during a read clears everything and restarts recovery.
        push(8'h3C);
        tick();
        chk("rst_mid_rd_en", {31'd0, rd_en}, 32'd1);
        reset = 1'b1; tick();
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_rx_reset", {31'd0, rx_reset}, 32'd0);
        chk("rst_dv", {31'd0, disp_valid}, 32'd0);
        chk("rst_disp", {24'd0, disp_msd, disp_lsd}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("rst_rx_reset_c%0d", i), {31'd0, rx_reset}, 32'd1);
        end
        tick();
        chk("rst_rx_reset_end", {31'd0, rx_reset}, 32'd0);
        chk("rst_dv_after", {31'd0, disp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
